// File: rtl/bm_pkg.sv
// Shared constants for the Booth-product accumulator: product width, default
// sizing and the two FSM state encodings.
package bm_pkg;

   localparam int PROD_W        = 10;
   localparam int ACC_W_DEF     = 16;
   localparam int MAX_TERMS_DEF = 8;

   localparam logic [0:0] ST_ACCUM = 1'b0;
   localparam logic [0:0] ST_HOLD  = 1'b1;

   // Two's-complement extremes of a W-bit signed value, used as clamp targets.
   function automatic logic [63:0] sat_max(input int w);
      logic [63:0] v;
      v = 64'd0;
      for (int i = 0; i < w - 1; i++) begin
         v[i] = 1'b1;
      end
      return v;
   endfunction

   function automatic logic [63:0] sat_min(input int w);
      logic [63:0] v;
      v = 64'd0;
      v[w-1] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational signed add that clamps to the W-bit range and flags any clamp.
module sat_add
   import bm_pkg::*;
#(
   parameter int W = ACC_W_DEF
) (
   input  logic [W-1:0] acc,
   input  logic [W-1:0] prod_ext,
   output logic [W-1:0] sum,
   output logic         sat_hit
);

   logic [W:0]    wide_s;
   logic [63:0]   max_s;
   logic [63:0]   min_s;

   assign max_s = sat_max(W);
   assign min_s = sat_min(W);

   // One extra bit of headroom: top two bits differing means the W-bit result overflowed.
   always_comb begin
      wide_s  = {acc[W-1], acc} + {prod_ext[W-1], prod_ext};
      sat_hit = 1'b0;
      sum     = wide_s[W-1:0];
      if (wide_s[W] != wide_s[W-1]) begin
         sat_hit = 1'b1;
         if (wide_s[W]) begin
            sum = min_s[W-1:0];
         end else begin
            sum = max_s[W-1:0];
         end
      end else begin
         sat_hit = 1'b0;
         sum     = wide_s[W-1:0];
      end
   end

endmodule

// File: rtl/bm_acc.sv
// Dot-product accumulator: sums signed Booth products into groups closed by
// prod_last or by reaching MAX_TERMS, then holds the result until taken.
module bm_acc
   import bm_pkg::*;
#(
   parameter int ACC_W     = ACC_W_DEF,
   parameter int MAX_TERMS = MAX_TERMS_DEF
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             prod_valid,
   output logic                             prod_ready,
   input  logic [PROD_W-1:0]                prod,
   input  logic                             prod_last,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [ACC_W-1:0]                 out_sum,
   output logic                             out_sat,
   output logic                             out_forced,
   output logic [$clog2(MAX_TERMS+1)-1:0]   out_terms
);

   localparam int CNT_W = $clog2(MAX_TERMS + 1);

   logic [0:0]        state_q, state_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              sat_q, sat_d;
   logic              forced_q, forced_d;
   logic              out_valid_q, out_valid_d;
   logic              prod_ready_q, prod_ready_d;

   logic [ACC_W-1:0]  prod_ext_s;
   logic [ACC_W-1:0]  sum_s;
   logic              sat_hit_s;
   logic [CNT_W-1:0]  cnt_inc_s;
   logic              close_s;

   assign prod_ext_s = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
   assign cnt_inc_s  = cnt_q + CNT_W'(1);
   assign close_s    = prod_last | (cnt_inc_s == CNT_W'(MAX_TERMS));

   sat_add #(
      .W        (ACC_W)
   ) u_sat_add (
      .acc      (acc_q),
      .prod_ext (prod_ext_s),
      .sum      (sum_s),
      .sat_hit  (sat_hit_s)
   );

   // Next-state logic: accumulate in ACCUM, wait for the consumer in HOLD.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      sat_d    = sat_q;
      forced_d = forced_q;
      case (state_q)
         ST_ACCUM: begin
            if (prod_valid) begin
               acc_d = sum_s;
               cnt_d = cnt_inc_s;
               sat_d = sat_q | sat_hit_s;
               if (close_s) begin
                  state_d  = ST_HOLD;
                  forced_d = ~prod_last;
               end else begin
                  state_d  = ST_ACCUM;
               end
            end else begin
               state_d = ST_ACCUM;
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               state_d  = ST_ACCUM;
               acc_d    = {ACC_W{1'b0}};
               cnt_d    = {CNT_W{1'b0}};
               sat_d    = 1'b0;
               forced_d = 1'b0;
            end else begin
               state_d  = ST_HOLD;
            end
         end
         default: begin
            state_d  = ST_ACCUM;
            acc_d    = {ACC_W{1'b0}};
            cnt_d    = {CNT_W{1'b0}};
            sat_d    = 1'b0;
            forced_d = 1'b0;
         end
      endcase
      out_valid_d  = (state_d == ST_HOLD);
      prod_ready_d = (state_d == ST_ACCUM);
   end

   // State and output registers; handshake flags are decoded from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_ACCUM;
         acc_q        <= {ACC_W{1'b0}};
         cnt_q        <= {CNT_W{1'b0}};
         sat_q        <= 1'b0;
         forced_q     <= 1'b0;
         out_valid_q  <= 1'b0;
         prod_ready_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         sat_q        <= sat_d;
         forced_q     <= forced_d;
         out_valid_q  <= out_valid_d;
         prod_ready_q <= prod_ready_d;
      end
   end

   assign prod_ready = prod_ready_q;
   assign out_valid  = out_valid_q;
   assign out_sum    = acc_q;
   assign out_terms  = cnt_q;
   assign out_sat    = sat_q;
   assign out_forced = forced_q;

endmodule
